// File: rtl/vga_segdac_driver.sv
// VGA timing generator with segmented-DAC colour encoding.
//
// Purpose:
//   Generates hpos/vpos raster counters and registered hsync/vsync/de/
//   frame_start. Each 8-bit colour channel is converted into a 12-bit switch
//   code for a four-segment DAC. Each segment takes two input bits and drives
//   a 3-level thermometer code.
//
// Ports:
//   clk            pixel clock
//   rst            synchronous, active-high reset
//   en             advance enable; all registers hold while low
//   pix_r/g/b[7:0] binary colour for the current hpos/vpos
//   test_sel       selects the colour-bar pattern (only with the macro below)
//   hpos/vpos[9:0] raster counters, used as the pixel request
//   hsync/vsync    active-low sync pulses, registered
//   de             data enable (visible area), registered
//   frame_start    one-cycle pulse for the output cycle of hpos=0, vpos=0
//   R/G/B[11:0]    DAC switch codes, bit = segment*3 + (level-1)
//
// Configuration macro:
//   VGA_SEGDAC_TEST_PATTERN_EN  adds the 64-pixel colour-bar generator,
//                               selected by test_sel. Without it test_sel
//                               is ignored.

module vga_segdac_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  input  logic        test_sel,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic [11:0] R,
  output logic [11:0] G,
  output logic [11:0] B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  r_hpos;
  logic [9:0]  r_vpos;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic        r_frame_start;
  logic [11:0] r_R;
  logic [11:0] r_G;
  logic [11:0] r_B;

  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_de_raw;
  logic        w_fs_raw;
  logic [7:0]  w_r;
  logic [7:0]  w_g;
  logic [7:0]  w_b;

  // Each 2-bit segment value n sets thermometer levels 1..n.
  function automatic logic [11:0] seg_encode(input logic [7:0] val);
    logic [11:0] code;
    logic [1:0]  n;
    code = '0;
    for (int s = 0; s < 4; s++) begin
      n = val[2*s +: 2];
      code[3*s +: 3] = {(n == 2'd3), (n >= 2'd2), (n != 2'd0)};
    end
    return code;
  endfunction

  assign w_hs_raw = ~((r_hpos >= HS_BEGIN) && (r_hpos < HS_END));
  assign w_vs_raw = ~((r_vpos >= VS_BEGIN) && (r_vpos < VS_END));
  assign w_de_raw = (r_hpos < H_VIS) && (r_vpos < V_VIS);
  assign w_fs_raw = (r_hpos == 10'd0) && (r_vpos == 10'd0);

`ifdef VGA_SEGDAC_TEST_PATTERN_EN
  assign w_r = test_sel ? {8{r_hpos[6]}} : pix_r;
  assign w_g = test_sel ? {8{r_hpos[7]}} : pix_g;
  assign w_b = test_sel ? {8{r_hpos[8]}} : pix_b;
`else
  logic w_unused_test_sel;
  assign w_unused_test_sel = test_sel;
  assign w_r = pix_r;
  assign w_g = pix_g;
  assign w_b = pix_b;
`endif

  // Output registers load from the same counter state that the pixel inputs
  // are sampled against, so everything lands one enabled cycle later.
  // frame_start holds while en=0, so a stalled 0,0 never produces a second
  // pulse: the next enabled cycle sees hpos=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
      r_R           <= '0;
      r_G           <= '0;
      r_B           <= '0;
    end else if (en) begin
      if (r_hpos == H_LAST) begin
        r_hpos <= '0;
        r_vpos <= (r_vpos == V_LAST) ? 10'd0 : r_vpos + 10'd1;
      end else begin
        r_hpos <= r_hpos + 10'd1;
      end
      r_hsync       <= w_hs_raw;
      r_vsync       <= w_vs_raw;
      r_de          <= w_de_raw;
      r_frame_start <= w_fs_raw;
      r_R           <= w_de_raw ? seg_encode(w_r) : 12'h000;
      r_G           <= w_de_raw ? seg_encode(w_g) : 12'h000;
      r_B           <= w_de_raw ? seg_encode(w_b) : 12'h000;
    end
  end

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign frame_start = r_frame_start;
  assign R           = r_R;
  assign G           = r_G;
  assign B           = r_B;

endmodule

// File: tb/tb_vga_segdac_driver.sv
// Directed bench for vga_segdac_driver. Horizontal timing uses the default
// 800-clock line; vertical timing is shortened to 18 lines
// (12 visible, fp 2, sync 2, bp 2) so whole frames fit in a short run.
module tb_vga_segdac_driver;

  localparam int V_ACT = 12;
  localparam int V_FPL = 2;
  localparam int V_SYN = 2;
  localparam int V_BPL = 2;
  localparam int FRAME = 800 * (V_ACT + V_FPL + V_SYN + V_BPL);

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        test_sel;
  logic [9:0]  hpos, vpos;
  logic        hsync, vsync, de, frame_start;
  logic [11:0] R, G, B;

  int checks = 0;
  int errors = 0;

  vga_segdac_driver #(
    .V_ACTIVE(V_ACT), .V_FP(V_FPL), .V_SYNC(V_SYN), .V_BP(V_BPL)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .test_sel(test_sel),
    .hpos(hpos), .vpos(vpos),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
    .R(R), .G(G), .B(B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_to(input logic [9:0] h, input logic [9:0] v);
    int n;
    n = 0;
    while (!(hpos === h && vpos === v) && n < 30000) begin
      step();
      n++;
    end
    chk("run_to_reached", {31'd0, (hpos === h && vpos === v)}, 32'd1);
  endtask

  initial begin
    int viol, hs_cnt, hs_start, vs_cnt, vs_start_h, vs_start_v, cyc;
    logic [9:0] prev_h, prev_v;

    rst = 1'b1; en = 1'b0; test_sel = 1'b0;
    pix_r = 8'h00; pix_g = 8'h00; pix_b = 8'h00;

    // Reset held 3 cycles with en low.
    step(); step(); step();
    chk("rst_hpos", hpos, 0);
    chk("rst_vpos", vpos, 0);
    chk("rst_R", R, 0);
    chk("rst_G", G, 0);
    chk("rst_B", B, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_fs", frame_start, 0);

    // Release: first enabled output cycle is for 0,0.
    rst = 1'b0; en = 1'b1; pix_r = 8'h55;
    step();
    chk("rel_fs", frame_start, 1);
    chk("rel_de", de, 1);
    chk("rel_R55", R, 12'h249);
    chk("rel_hpos", hpos, 1);
    step();
    chk("rel_fs_drop", frame_start, 0);

    // Encoder at hpos=10, vpos=10.
    run_to(10'd10, 10'd10);
    pix_r = 8'hE4; pix_g = 8'hFF; pix_b = 8'h00;
    step();
    chk("enc_R", R, 12'hEC8);
    chk("enc_G", G, 12'hFFF);
    chk("enc_B", B, 12'h000);
    chk("enc_de", de, 1);

    // Horizontal blanking with full-scale pixels.
    pix_r = 8'hFF; pix_g = 8'hFF; pix_b = 8'hFF;
    run_to(10'd639, 10'd10);
    step();
    chk("blank_639_R", R, 12'hFFF);
    chk("blank_639_de", de, 1);
    step();
    chk("blank_640_R", R, 12'h000);
    chk("blank_640_G", G, 12'h000);
    chk("blank_640_de", de, 0);
    viol = 0;
    for (int i = 0; i < 159; i++) begin
      step();
      if (R !== 12'h000 || G !== 12'h000 || B !== 12'h000 || de !== 1'b0) viol++;
    end
    chk("blank_641_799_viol", viol, 0);

    // hsync over one line.
    run_to(10'd0, 10'd11);
    hs_cnt = 0; hs_start = -1;
    for (int i = 0; i < 800; i++) begin
      prev_h = hpos;
      step();
      if (hsync === 1'b0) begin
        if (hs_cnt == 0) hs_start = int'(prev_h);
        hs_cnt++;
      end
    end
    chk("hsync_len", hs_cnt, 96);
    chk("hsync_start", hs_start, 656);

    // One full frame: period, vsync, vertical blanking.
    run_to(10'd0, 10'd0);
    step();
    chk("frame_fs", frame_start, 1);
    cyc = 0; viol = 0; vs_cnt = 0; vs_start_h = -1; vs_start_v = -1;
    while (cyc < 20000) begin
      prev_h = hpos; prev_v = vpos;
      step();
      cyc++;
      if (vsync === 1'b0) begin
        if (vs_cnt == 0) begin
          vs_start_h = int'(prev_h);
          vs_start_v = int'(prev_v);
        end
        vs_cnt++;
      end
      if (prev_v >= 10'(V_ACT) && (R !== 12'h000 || G !== 12'h000 || B !== 12'h000 || de !== 1'b0))
        viol++;
      if (frame_start === 1'b1) break;
    end
    chk("frame_period", cyc, FRAME);
    chk("vsync_len", vs_cnt, 1600);
    chk("vsync_start_v", vs_start_v, V_ACT + V_FPL);
    chk("vsync_start_h", vs_start_h, 0);
    chk("vblank_viol", viol, 0);

    // Stall at the last pixel of the frame.
    run_to(10'd799, 10'd17);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_hpos", hpos, 799);
      chk("frz_vpos", vpos, 17);
      chk("frz_sync", {hsync, vsync, de, frame_start}, 4'b1100);
      chk("frz_R", R, 0);
    end
    en = 1'b1;
    step();
    chk("wrap_pos", {hpos, vpos}, 20'd0);
    chk("wrap_fs_pre", frame_start, 0);
    step();
    chk("wrap_fs", frame_start, 1);
    step();
    chk("wrap_fs_once", frame_start, 0);

    // Mid-frame reset.
    run_to(10'd300, 10'd8);
    rst = 1'b1;
    step();
    chk("mrst_pos", {hpos, vpos}, 20'd0);
    chk("mrst_fs", frame_start, 0);
    chk("mrst_R", R, 0);
    chk("mrst_hsync", hsync, 1);
    rst = 1'b0;
    step();
    chk("mrst_fs_rel", frame_start, 1);
    chk("mrst_hpos", hpos, 1);
    chk("mrst_vpos", vpos, 0);

    // Colour bars at hpos=64.
    run_to(10'd64, 10'd1);
    test_sel = 1'b1;
    pix_r = 8'h00; pix_g = 8'hFF; pix_b = 8'hFF;
    step();
`ifdef VGA_SEGDAC_TEST_PATTERN_EN
    chk("tp_R", R, 12'hFFF);
    chk("tp_G", G, 12'h000);
    chk("tp_B", B, 12'h000);
`else
    chk("tp_R", R, 12'h000);
    chk("tp_G", G, 12'hFFF);
    chk("tp_B", B, 12'hFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
